// File: rtl/if_id_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_skid_reg
//  Purpose  : IF/ID pipeline register with a valid/ready handshake and a
//             2-entry skid buffer. in_ready is a pure register decode, so
//             fetch timing stays fully registered. When decode stalls,
//             in_ready drops one cycle late and the skid register catches
//             the in-flight instruction. flush kills every held and incoming
//             entry. A saturating counter reports the number of decode stall
//             cycles.
//  Ports    : clk        rising-edge clock
//             rst        asynchronous, active-low reset
//             in_valid   fetch presents in_pc_4/in_ins
//             in_ready   stage can accept (registered, equals !skid_v)
//             in_pc_4    fetch PC+4
//             in_ins     fetched instruction
//             flush      synchronous kill of held and incoming entries
//             out_valid  head entry is live
//             out_ready  decode consumes the head entry
//             out_pc_4   PC+4 of the head entry (last value held)
//             out_ins    head instruction, NOP when out_valid=0
//             occ        number of entries held (0..2)
//             stall_cnt  saturating count of out_valid & !out_ready cycles
//  Revision : 1.0 - initial release
// ============================================================================
module if_id_skid_reg #(
  parameter int               PC_W  = 32,
  parameter int               INS_W = 32,
  parameter logic [INS_W-1:0] NOP   = {INS_W{1'b0}},
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc_4,
  input  logic [INS_W-1:0] in_ins,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc_4,
  output logic [INS_W-1:0] out_ins,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  // Head entry drives the outputs; skid entry only ever refills the head.
  logic             r_main_v;
  logic [PC_W-1:0]  r_main_pc_4;
  logic [INS_W-1:0] r_main_ins;
  logic             r_skid_v;
  logic [PC_W-1:0]  r_skid_pc_4;
  logic [INS_W-1:0] r_skid_ins;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_stall;

  assign w_stall = r_main_v & ~out_ready;

  // ---------------------------------------------------------------------------
  // Entry storage. The occupancy state is implied by the two valid bits:
  //   main_v=0            -> EMPTY (skid_v is never set while main is empty)
  //   main_v=1, skid_v=0  -> ONE
  //   main_v=1, skid_v=1  -> FULL
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_v    <= 1'b0;
      r_main_pc_4 <= {PC_W{1'b0}};
      r_main_ins  <= NOP;
      r_skid_v    <= 1'b0;
      r_skid_pc_4 <= {PC_W{1'b0}};
      r_skid_ins  <= NOP;
    end else if (flush) begin
      // Any handshake completing this cycle is accepted but discarded;
      // main_pc_4 is left alone so out_pc_4 holds its last value.
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (!r_main_v) begin
      if (in_valid) begin
        r_main_v    <= 1'b1;
        r_main_pc_4 <= in_pc_4;
        r_main_ins  <= in_ins;
      end
    end else if (!r_skid_v) begin
      if (out_ready) begin
        if (in_valid) begin
          r_main_pc_4 <= in_pc_4;
          r_main_ins  <= in_ins;
        end else begin
          r_main_v <= 1'b0;
        end
      end else if (in_valid) begin
        // Decode stalled but in_ready was still high: catch the instruction.
        r_skid_v    <= 1'b1;
        r_skid_pc_4 <= in_pc_4;
        r_skid_ins  <= in_ins;
      end
    end else begin
      // FULL: in_valid is ignored because in_ready=0.
      if (out_ready) begin
        r_main_pc_4 <= r_skid_pc_4;
        r_main_ins  <= r_skid_ins;
        r_skid_v    <= 1'b0;
      end
    end
  end

  // Stall counter is cleared only by reset; flush leaves it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (w_stall && (r_stall_cnt != C_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign in_ready  = ~r_skid_v;
  assign out_valid = r_main_v;
  assign out_pc_4  = r_main_pc_4;
  assign out_ins   = r_main_v ? r_main_ins : NOP;
  assign occ       = {1'b0, r_main_v} + {1'b0, r_skid_v};
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_id_skid_reg
//  Purpose  : Self-checking bench for if_id_skid_reg. A queue-based model of
//             the stage (at most two entries, FIFO order) plus a stall
//             counter provides every expected value. A second instance with
//             a 4-bit counter shares all inputs to exercise saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_skid_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc_4 = '0;
  logic [31:0] in_ins = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc_4;
  logic [31:0] out_ins;
  logic [1:0]  occ;
  logic [15:0] stall_cnt;

  logic        in_ready_4;
  logic        out_valid_4;
  logic [31:0] out_pc_4_4;
  logic [31:0] out_ins_4;
  logic [1:0]  occ_4;
  logic [3:0]  stall_cnt_4;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [63:0] q[$];          // {pc_4, ins}, head at index 0
  int          exp_cnt  = 0;
  int          exp_cnt4 = 0;
  logic [31:0] last_pc  = '0;

  always #5 clk = ~clk;

  if_id_skid_reg #(.PC_W(32), .INS_W(32), .NOP(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc_4(in_pc_4), .in_ins(in_ins), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc_4(out_pc_4),
    .out_ins(out_ins), .occ(occ), .stall_cnt(stall_cnt)
  );

  if_id_skid_reg #(.PC_W(32), .INS_W(32), .NOP(32'h0), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_4),
    .in_pc_4(in_pc_4), .in_ins(in_ins), .flush(flush),
    .out_valid(out_valid_4), .out_ready(out_ready), .out_pc_4(out_pc_4_4),
    .out_ins(out_ins_4), .occ(occ_4), .stall_cnt(stall_cnt_4)
  );

  // Model helpers (no comparisons here)
  function automatic logic [31:0] exp_ins();
    logic [63:0] e;
    if (q.size() == 0) return 32'h0;
    e = q[0];
    return e[31:0];
  endfunction

  // Advance one clock edge and update the model; sampling point is 1 ns after.
  task automatic tick();
    int          sz;
    bit          pop, push, stall;
    logic [63:0] din, h;
    sz    = q.size();
    pop   = (sz > 0) && out_ready;
    push  = in_valid && (sz < 2);
    stall = (sz > 0) && !out_ready;
    din   = {in_pc_4, in_ins};
    @(posedge clk);
    #1;
    if (stall) begin
      if (exp_cnt < 65535) exp_cnt++;
      if (exp_cnt4 < 15) exp_cnt4++;
    end
    if (pop) void'(q.pop_front());
    if (push) q.push_back(din);
    if (flush) q.delete();
    if (q.size() > 0) begin
      h = q[0];
      last_pc = h[63:32];
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_cnt  = 0;
    exp_cnt4 = 0;
    last_pc  = '0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    n_checks++; if (out_ins !== 32'h0) begin n_fail++; $display("FAIL reset_out_ins got=%h exp=0", out_ins); end
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL reset_occ got=%0d exp=0", occ); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    n_checks++; if (out_pc_4 !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc_4 got=%h exp=0", out_pc_4); end
    model_reset();
    @(negedge clk);
    while ($time < 100) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_stream();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_ins  = 32'h00000824 + i;
      in_pc_4 = 4 * (i + 1);
      tick();
      n_checks++; if (out_ins !== 32'h00000824 + i) begin n_fail++; $display("FAIL stream_ins[%0d] got=%h exp=%h", i, out_ins, 32'h00000824 + i); end
      n_checks++; if (out_pc_4 !== 4 * (i + 1)) begin n_fail++; $display("FAIL stream_pc[%0d] got=%0d exp=%0d", i, out_pc_4, 4 * (i + 1)); end
      n_checks++; if (occ !== 2'd1 || in_ready !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_ctl[%0d] got occ=%0d rdy=%0b v=%0b exp occ=1 rdy=1 v=1", i, occ, in_ready, out_valid); end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (occ !== 2'd0 || out_ins !== 32'h0) begin n_fail++; $display("FAIL stream_drain got occ=%0d ins=%h exp occ=0 ins=0", occ, out_ins); end
  endtask

  task automatic test_backpressure();
    logic [31:0] vals [3];
    logic [1:0]  exp_occ [3];
    vals = '{32'h11, 32'h22, 32'h33};
    exp_occ = '{2'd1, 2'd2, 2'd2};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_ins  = vals[i];
      in_pc_4 = 32'h100 + 4 * i;
      tick();
      n_checks++; if (occ !== exp_occ[i]) begin n_fail++; $display("FAIL bp_occ[%0d] got=%0d exp=%0d", i, occ, exp_occ[i]); end
      n_checks++; if (out_ins !== 32'h11) begin n_fail++; $display("FAIL bp_head[%0d] got=%h exp=11", i, out_ins); end
      n_checks++; if (in_ready !== (i == 0)) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%0b exp=%0b", i, in_ready, (i == 0)); end
      n_checks++; if (stall_cnt !== 16'(i)) begin n_fail++; $display("FAIL bp_stall_cnt[%0d] got=%0d exp=%0d", i, stall_cnt, i); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_drain();
    logic [31:0] e_ins [3];
    logic [1:0]  e_occ [3];
    e_ins = '{32'h22, 32'h0, 32'h0};
    e_occ = '{2'd1, 2'd0, 2'd0};
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_ins !== e_ins[i]) begin n_fail++; $display("FAIL drain_ins[%0d] got=%h exp=%h", i, out_ins, e_ins[i]); end
      n_checks++; if (occ !== e_occ[i] || out_valid !== (e_occ[i] != 0)) begin n_fail++; $display("FAIL drain_ctl[%0d] got occ=%0d v=%0b exp occ=%0d", i, occ, out_valid, e_occ[i]); end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ins = 32'hA2; in_pc_4 = 32'h200; tick();
    in_ins = 32'hB2; in_pc_4 = 32'h204; tick();
    n_checks++; if (occ !== 2'd2) begin n_fail++; $display("FAIL flush_prefill got occ=%0d exp=2", occ); end
    in_ins = 32'hD2; in_pc_4 = 32'h208; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (occ !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ctl got occ=%0d v=%0b rdy=%0b exp 0/0/1", occ, out_valid, in_ready); end
    n_checks++; if (out_ins !== 32'h0) begin n_fail++; $display("FAIL flush_ins got=%h exp=0", out_ins); end
    n_checks++; if (out_pc_4 !== 32'h200) begin n_fail++; $display("FAIL flush_pc got=%h exp=200", out_pc_4); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_ins !== 32'h0) begin n_fail++; $display("FAIL flush_no_ghost got v=%0b ins=%h exp 0/0", out_valid, out_ins); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ins = 32'h55; in_pc_4 = 32'h300; tick();
    in_ins = 32'h66; in_pc_4 = 32'h304; tick();
    in_valid = 1'b0;
    tick();
    n_checks++; if (occ !== 2'd2 || stall_cnt === 16'd0) begin n_fail++; $display("FAIL areset_prefill got occ=%0d cnt=%0d exp occ=2 cnt>0", occ, stall_cnt); end
    #1 rst = 1'b0;   // between edges
    #1;
    model_reset();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occ !== 2'd0) begin n_fail++; $display("FAIL areset_ctl got v=%0b rdy=%0b occ=%0d exp 0/1/0", out_valid, in_ready, occ); end
    n_checks++; if (stall_cnt !== 16'd0 || stall_cnt_4 !== 4'd0) begin n_fail++; $display("FAIL areset_cnt got=%0d/%0d exp=0", stall_cnt, stall_cnt_4); end
    n_checks++; if (out_pc_4 !== 32'h0 || out_ins !== 32'h0) begin n_fail++; $display("FAIL areset_data got pc=%h ins=%h exp 0/0", out_pc_4, out_ins); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ins = 32'h77; in_pc_4 = 32'h400;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++; if (int'(stall_cnt_4) !== exp_cnt4) begin n_fail++; $display("FAIL sat_cnt4[%0d] got=%0d exp=%0d", i, stall_cnt_4, exp_cnt4); end
    end
    n_checks++; if (stall_cnt_4 !== 4'd15) begin n_fail++; $display("FAIL sat_final got=%0d exp=15", stall_cnt_4); end
    n_checks++; if (stall_cnt !== 16'd20) begin n_fail++; $display("FAIL sat_wide got=%0d exp=20", stall_cnt); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 5);
      in_ins    = $urandom;
      in_pc_4   = $urandom;
      tick();
      n_checks++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) ||
          occ !== 2'(q.size()) || out_ins !== exp_ins() ||
          out_pc_4 !== last_pc || int'(stall_cnt) !== exp_cnt ||
          int'(stall_cnt_4) !== exp_cnt4) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL rand[%0d] got v=%0b rdy=%0b occ=%0d ins=%h pc=%h cnt=%0d cnt4=%0d exp v=%0b rdy=%0b occ=%0d ins=%h pc=%h cnt=%0d cnt4=%0d",
                   i, out_valid, in_ready, occ, out_ins, out_pc_4, stall_cnt, stall_cnt_4,
                   (q.size() > 0), (q.size() < 2), q.size(), exp_ins(), last_pc, exp_cnt, exp_cnt4);
        errs++;
      end
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_drain();
    test_flush();
    test_async_reset();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
